// File: rtl/ltssm_pkg.sv
// Shared LTSSM types.
//   os_type_e    : ordered-set type requested from / decoded by the OS path.
//   polling_sm_e : Polling substate encoding, exported on poll_state.
//                  POLLING_SPEED is reserved for speed negotiation and is not
//                  entered by the Polling controller.
//   os_qualifies : whether a decoded OS counts toward the consecutive-match
//                  requirement in a given substate.
package ltssm_pkg;

  typedef enum logic [1:0] {
    OS_NONE       = 2'd0,
    OS_TS1        = 2'd1,
    OS_TS2        = 2'd2,
    OS_COMPLIANCE = 2'd3
  } os_type_e;

  typedef enum logic [3:0] {
    POLLING_IDLE       = 4'd0,
    POLLING_ACTIVE     = 4'd1,
    POLLING_COMPLIANCE = 4'd2,
    POLLING_CONFIG     = 4'd3,
    POLLING_SPEED      = 4'd4
  } polling_sm_e;

  // Active accepts TS1 or TS2; Configuration accepts only TS2.
  function automatic logic os_qualifies(input polling_sm_e st,
                                        input logic [1:0]  os_type,
                                        input logic        os_ok);
    logic q;
    q = 1'b0;
    if (os_ok) begin
      case (st)
        POLLING_ACTIVE: q = (os_type == OS_TS1) || (os_type == OS_TS2);
        POLLING_CONFIG: q = (os_type == OS_TS2);
        default:        q = 1'b0;
      endcase
    end
    return q;
  endfunction

endpackage

// File: rtl/ltssm_consec_cnt.sv
// Saturating consecutive-match counter.
//   clk, rst_n : clock, synchronous active-low reset
//   i_clr      : synchronous clear (takes priority over counting)
//   i_valid    : one observation this cycle
//   i_match    : observation qualifies (+1, saturating); otherwise clear
//   o_cnt      : current consecutive count, saturates at MAX
module ltssm_consec_cnt #(
  parameter int MAX = 8,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_valid,
  input  logic         i_match,
  output logic [W-1:0] o_cnt
);

  localparam logic [W-1:0] MAX_W = W'(MAX);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || i_clr) begin
      r_cnt <= '0;
    end else if (i_valid) begin
      if (!i_match)
        r_cnt <= '0;
      else if (r_cnt != MAX_W)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/ltssm_polling_ctrl.sv
// LTSSM Polling substate sequencer for one link.
//   clk, rst_n          : core clock, synchronous active-low reset
//   start / abort       : pulses from the top-level LTSSM (enter / force exit)
//   tx_os_type          : OS type requested from the OS transmitter
//   tx_os_done          : pulse, one requested OS fully sent
//   rx_os_valid/type/ok : one decoded OS, its type, PAD-fields-and-error-free
//   rx_eidle_exit       : electrical-idle exit seen on any lane
//   poll_state, busy    : registered substate and not-idle status
//   done_config/detect  : one-cycle exit verdict, coincident with return to IDLE
module ltssm_polling_ctrl
  import ltssm_pkg::*;
#(
  parameter int TX_MIN_TS1     = 1024,
  parameter int RX_CONSEC      = 8,
  parameter int TX_TS2_AFTER   = 16,
  parameter int ACTIVE_TIMEOUT = 6000000,
  parameter int CONFIG_TIMEOUT = 12000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic [1:0] tx_os_type,
  input  logic       tx_os_done,
  input  logic       rx_os_valid,
  input  logic [1:0] rx_os_type,
  input  logic       rx_os_ok,
  input  logic       rx_eidle_exit,
  output logic [3:0] poll_state,
  output logic       busy,
  output logic       done_config,
  output logic       done_detect
);

  localparam int TX_MAX = (TX_MIN_TS1 > TX_TS2_AFTER) ? TX_MIN_TS1 : TX_TS2_AFTER;
  localparam int TXW    = $clog2(TX_MAX + 1);
  localparam int RXW    = $clog2(RX_CONSEC + 1);
  localparam int TMW    = $clog2(CONFIG_TIMEOUT + 1);

  localparam logic [TXW-1:0] TX_ACT_THR = TXW'(TX_MIN_TS1);
  localparam logic [TXW-1:0] TX_CFG_THR = TXW'(TX_TS2_AFTER);
  localparam logic [RXW-1:0] RX_THR     = RXW'(RX_CONSEC);
  localparam logic [TMW-1:0] ACT_LAST   = TMW'(ACTIVE_TIMEOUT - 1);
  localparam logic [TMW-1:0] CFG_LAST   = TMW'(CONFIG_TIMEOUT - 1);

  polling_sm_e    r_state;
  logic [TXW-1:0] r_tx_cnt;
  logic [TMW-1:0] r_timer;
  logic           r_ts2_seen;
  logic [1:0]     r_tx_os_type;
  logic           r_busy;
  logic           r_done_config;
  logic           r_done_detect;

  logic [RXW-1:0] w_rx_cnt;
  logic           w_in_train;
  logic           w_rx_match;
  logic           w_rx_sat;
  logic [TXW-1:0] w_tx_thr;
  logic           w_tx_inc;
  logic           w_act_ok;
  logic           w_act_to;
  logic           w_cfg_ok;
  logic           w_cfg_to;
  logic           w_state_chg;

  assign w_in_train = (r_state == POLLING_ACTIVE) || (r_state == POLLING_CONFIG);
  assign w_rx_match = os_qualifies(r_state, rx_os_type, rx_os_ok);
  assign w_rx_sat   = (w_rx_cnt >= RX_THR);

  // tx_cnt threshold depends on the substate; in Configuration only sends
  // after the first received TS2 count (registered flag, so a send on the
  // same cycle as that TS2 is excluded).
  assign w_tx_thr = (r_state == POLLING_CONFIG) ? TX_CFG_THR : TX_ACT_THR;
  assign w_tx_inc = tx_os_done && (r_tx_cnt < w_tx_thr) &&
                    ((r_state == POLLING_ACTIVE) ||
                     ((r_state == POLLING_CONFIG) && r_ts2_seen));

  assign w_act_ok = (r_tx_cnt >= TX_ACT_THR) && w_rx_sat;
  assign w_act_to = (r_timer == ACT_LAST);
  assign w_cfg_ok = (r_tx_cnt >= TX_CFG_THR) && w_rx_sat;
  assign w_cfg_to = (r_timer == CFG_LAST);

  // Any transition out of the current substate; drives the counter clears.
  always_comb begin
    w_state_chg = 1'b0;
    case (r_state)
      POLLING_IDLE:       w_state_chg = start;
      POLLING_ACTIVE:     w_state_chg = abort || w_act_ok || w_act_to;
      POLLING_COMPLIANCE: w_state_chg = abort || rx_eidle_exit;
      POLLING_CONFIG:     w_state_chg = abort || w_cfg_ok || w_cfg_to;
      default:            w_state_chg = 1'b1;
    endcase
  end

  ltssm_consec_cnt #(
    .MAX (RX_CONSEC),
    .W   (RXW)
  ) u_rx_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_state_chg),
    .i_valid (rx_os_valid && w_in_train),
    .i_match (w_rx_match),
    .o_cnt   (w_rx_cnt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= POLLING_IDLE;
      r_tx_cnt      <= '0;
      r_timer       <= '0;
      r_ts2_seen    <= 1'b0;
      r_tx_os_type  <= OS_NONE;
      r_busy        <= 1'b0;
      r_done_config <= 1'b0;
      r_done_detect <= 1'b0;
    end else begin
      r_done_config <= 1'b0;
      r_done_detect <= 1'b0;

      if (w_state_chg) begin
        r_tx_cnt   <= '0;
        r_timer    <= '0;
        r_ts2_seen <= 1'b0;
      end else begin
        if (w_tx_inc)
          r_tx_cnt <= r_tx_cnt + 1'b1;
        if (w_in_train)
          r_timer <= r_timer + 1'b1;
        if ((r_state == POLLING_CONFIG) && rx_os_valid && w_rx_match)
          r_ts2_seen <= 1'b1;
      end

      case (r_state)
        POLLING_IDLE: begin
          if (start) begin
            r_state      <= POLLING_ACTIVE;
            r_tx_os_type <= OS_TS1;
            r_busy       <= 1'b1;
          end
        end
        POLLING_ACTIVE: begin
          if (abort) begin
            r_state      <= POLLING_IDLE;
            r_tx_os_type <= OS_NONE;
            r_busy       <= 1'b0;
          end else if (w_act_ok || (w_act_to && w_rx_sat)) begin
            r_state      <= POLLING_CONFIG;
            r_tx_os_type <= OS_TS2;
          end else if (w_act_to) begin
            r_state      <= POLLING_COMPLIANCE;
            r_tx_os_type <= OS_COMPLIANCE;
          end
        end
        POLLING_COMPLIANCE: begin
          if (abort) begin
            r_state      <= POLLING_IDLE;
            r_tx_os_type <= OS_NONE;
            r_busy       <= 1'b0;
          end else if (rx_eidle_exit) begin
            r_state      <= POLLING_ACTIVE;
            r_tx_os_type <= OS_TS1;
          end
        end
        POLLING_CONFIG: begin
          if (abort) begin
            r_state      <= POLLING_IDLE;
            r_tx_os_type <= OS_NONE;
            r_busy       <= 1'b0;
          end else if (w_cfg_ok) begin
            r_state       <= POLLING_IDLE;
            r_tx_os_type  <= OS_NONE;
            r_busy        <= 1'b0;
            r_done_config <= 1'b1;
          end else if (w_cfg_to) begin
            r_state       <= POLLING_IDLE;
            r_tx_os_type  <= OS_NONE;
            r_busy        <= 1'b0;
            r_done_detect <= 1'b1;
          end
        end
        default: begin
          r_state      <= POLLING_IDLE;
          r_tx_os_type <= OS_NONE;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign tx_os_type  = r_tx_os_type;
  assign poll_state  = r_state;
  assign busy        = r_busy;
  assign done_config = r_done_config;
  assign done_detect = r_done_detect;

endmodule

// File: tb/tb_ltssm_polling_ctrl.sv
module tb_ltssm_polling_ctrl;
  import ltssm_pkg::*;

  localparam int K_SNAP = 0;
  localparam int K_CFG  = 1;
  localparam int K_DET  = 2;

  localparam int ST_IDLE = 0;
  localparam int ST_ACT  = 1;
  localparam int ST_CMP  = 2;
  localparam int ST_CFG  = 3;

  typedef struct {
    int    kind;
    string name;
    int    st;
    int    os;
    int    bz;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [1:0] tx_os_type;
  logic       tx_os_done;
  logic       rx_os_valid;
  logic [1:0] rx_os_type;
  logic       rx_os_ok;
  logic       rx_eidle_exit;
  logic [3:0] poll_state;
  logic       busy;
  logic       done_config;
  logic       done_detect;
  logic       probe;

  exp_t exp_q[$];
  exp_t e_mon;
  int   total = 0;
  int   bad   = 0;

  ltssm_polling_ctrl #(
    .TX_MIN_TS1     (16),
    .RX_CONSEC      (8),
    .TX_TS2_AFTER   (16),
    .ACTIVE_TIMEOUT (200),
    .CONFIG_TIMEOUT (400)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .abort         (abort),
    .tx_os_type    (tx_os_type),
    .tx_os_done    (tx_os_done),
    .rx_os_valid   (rx_os_valid),
    .rx_os_type    (rx_os_type),
    .rx_os_ok      (rx_os_ok),
    .rx_eidle_exit (rx_eidle_exit),
    .poll_state    (poll_state),
    .busy          (busy),
    .done_config   (done_config),
    .done_detect   (done_detect)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  // Monitor: pulses are matched first, then status probes.
  always @(negedge clk) begin
    if (done_config && done_detect) begin
      total++;
      bad++;
      $display("FAIL both_done: got cfg=1 det=1, required at most one");
    end
    if (done_config || done_detect) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: got cfg=%0d det=%0d, required none",
                 done_config, done_detect);
      end else begin
        e_mon = exp_q.pop_front();
        chk({e_mon.name, ".kind"}, done_config ? K_CFG : K_DET, e_mon.kind);
        chk({e_mon.name, ".state"}, int'(poll_state), ST_IDLE);
        chk({e_mon.name, ".busy"}, int'(busy), 0);
      end
    end
    if (probe) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL orphan_probe: got state=%0d, required an expectation", poll_state);
      end else begin
        e_mon = exp_q.pop_front();
        chk({e_mon.name, ".kind"}, K_SNAP, e_mon.kind);
        chk({e_mon.name, ".state"}, int'(poll_state), e_mon.st);
        chk({e_mon.name, ".os"}, int'(tx_os_type), e_mon.os);
        chk({e_mon.name, ".busy"}, int'(busy), e_mon.bz);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snap(input string nm, input int st, input int os, input int bz);
    exp_t e;
    e.kind = K_SNAP; e.name = nm; e.st = st; e.os = os; e.bz = bz;
    exp_q.push_back(e);
    probe = 1'b1;
    tick();
    probe = 1'b0;
  endtask

  task automatic expect_pulse(input string nm, input int kind);
    exp_t e;
    e.kind = kind; e.name = nm; e.st = ST_IDLE; e.os = 0; e.bz = 0;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input bit st, input bit ab, input bit txd, input bit rxv,
                     input logic [1:0] rt, input bit ok, input bit eid);
    start = st; abort = ab; tx_os_done = txd; rx_os_valid = rxv;
    rx_os_type = rt; rx_os_ok = ok; rx_eidle_exit = eid;
    tick();
    start = 0; abort = 0; tx_os_done = 0; rx_os_valid = 0;
    rx_os_type = 2'd0; rx_os_ok = 0; rx_eidle_exit = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion, required finish within budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 0; start = 0; abort = 0; tx_os_done = 0; rx_os_valid = 0;
    rx_os_type = 2'd0; rx_os_ok = 0; rx_eidle_exit = 0; probe = 0;
    repeat (3) tick();
    rst_n = 1;
    snap("reset", ST_IDLE, 0, 0);

    // Happy path
    cyc(1, 0, 0, 0, 2'd0, 0, 0);
    snap("hp_active", ST_ACT, 1, 1);
    for (int i = 0; i < 16; i++) cyc(0, 0, 1, i < 8, 2'd1, 1, 0);
    snap("hp_still_active", ST_ACT, 1, 1);
    snap("hp_config", ST_CFG, 2, 1);
    for (int i = 0; i < 16; i++) cyc(0, 0, 1, i < 8, 2'd2, 1, 0);
    snap("hp_tx15_hold", ST_CFG, 2, 1);
    cyc(0, 0, 1, 0, 2'd0, 0, 0);
    tick();
    expect_pulse("hp_done", K_CFG);
    snap("hp_idle", ST_IDLE, 0, 0);

    // Consecutive break
    cyc(1, 0, 0, 0, 2'd0, 0, 0);
    snap("brk_active", ST_ACT, 1, 1);
    for (int i = 0; i < 16; i++) cyc(0, 0, 1, 0, 2'd0, 0, 0);
    for (int i = 0; i < 7; i++) cyc(0, 0, 0, 1, 2'd1, 1, 0);
    cyc(0, 0, 0, 1, 2'd1, 0, 0);
    for (int i = 0; i < 7; i++) cyc(0, 0, 0, 1, 2'd1, 1, 0);
    snap("brk_seven", ST_ACT, 1, 1);
    cyc(0, 0, 0, 1, 2'd2, 1, 0);
    snap("brk_eighth", ST_ACT, 1, 1);
    snap("brk_config", ST_CFG, 2, 1);

    // Abort in Configuration, then restart
    cyc(0, 1, 0, 0, 2'd0, 0, 0);
    snap("abort_idle", ST_IDLE, 0, 0);
    cyc(1, 0, 0, 0, 2'd0, 0, 0);
    snap("restart_active", ST_ACT, 1, 1);

    // Active timeout -> Compliance (start inside ACTIVE is ignored)
    repeat (49) tick();
    cyc(1, 0, 0, 0, 2'd0, 0, 0);
    repeat (147) tick();
    snap("ato_198", ST_ACT, 1, 1);
    snap("ato_199", ST_ACT, 1, 1);
    snap("ato_compliance", ST_CMP, 3, 1);
    cyc(0, 0, 0, 0, 2'd0, 0, 1);
    snap("eidle_active", ST_ACT, 1, 1);

    // Second timeout with rx satisfied -> Configuration
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1, 2'd1, 1, 0);
    repeat (189) tick();
    snap("ato2_198", ST_ACT, 1, 1);
    snap("ato2_199", ST_ACT, 1, 1);
    snap("ato2_config", ST_CFG, 2, 1);

    // Config timeout with only TS1 received
    for (int i = 0; i < 397; i++) cyc(0, 0, 1, 1, 2'd1, 1, 0);
    snap("cto_398", ST_CFG, 2, 1);
    snap("cto_399", ST_CFG, 2, 1);
    expect_pulse("cto_detect", K_DET);
    snap("cto_idle", ST_IDLE, 0, 0);

    // Success on the exact timeout cycle
    cyc(1, 0, 0, 0, 2'd0, 0, 0);
    for (int i = 0; i < 16; i++) cyc(0, 0, 1, i < 8, 2'd1, 1, 0);
    tick();
    snap("sim_config", ST_CFG, 2, 1);
    repeat (381) tick();
    for (int i = 0; i < 17; i++) cyc(0, 0, 1, i < 8, 2'd2, 1, 0);
    tick();
    expect_pulse("sim_done", K_CFG);
    snap("sim_idle", ST_IDLE, 0, 0);

    // Reset in ACTIVE
    cyc(1, 0, 0, 0, 2'd0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, 2'd0, 0, 0);
    rst_n = 0;
    tick();
    snap("rst_mid", ST_IDLE, 0, 0);
    rst_n = 1;
    tick();
    cyc(1, 0, 0, 0, 2'd0, 0, 0);
    for (int i = 0; i < 15; i++) cyc(0, 0, 1, i < 8, 2'd1, 1, 0);
    snap("rst_tx_cleared", ST_ACT, 1, 1);
    snap("rst_tx_cleared2", ST_ACT, 1, 1);
    cyc(0, 1, 0, 0, 2'd0, 0, 0);
    snap("rst_abort_idle", ST_IDLE, 0, 0);

    repeat (3) tick();
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      total++;
      bad++;
      $display("FAIL %s.missing: got no event, required kind %0d", e.name, e.kind);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
